// File: rtl/axis_pkt_mux_if.sv
// axis_pkt_mux_if: slave streams, master stream, select and status of the packet mux
interface axis_pkt_mux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH*DATA_W-1:0] S_TDATA;
    logic [NUM_CH-1:0] S_TVALID;
    logic [NUM_CH-1:0] S_TLAST;
    logic [NUM_CH-1:0] S_TREADY;
    logic [SEL_W-1:0] sel;
    logic [DATA_W-1:0] M_TDATA;
    logic M_TVALID;
    logic M_TLAST;
    logic M_TREADY;
    logic busy;
    logic [SEL_W-1:0] grant;
    modport slave (
        input S_TDATA, S_TVALID, S_TLAST, sel, M_TREADY,
        output S_TREADY, M_TDATA, M_TVALID, M_TLAST, busy, grant
    );
    modport master (
        output S_TDATA, S_TVALID, S_TLAST, sel, M_TREADY,
        input S_TREADY, M_TDATA, M_TVALID, M_TLAST, busy, grant
    );
endinterface

// File: rtl/axis_pkt_mux.sv
// axis_pkt_mux: packet-locked N:1 AXI-Stream mux with a registered output stage,
// channel chosen by sel (MODE=0) or round-robin (MODE=1) and held until TLAST.
module axis_pkt_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int MODE = 0
) (
    input logic ACLK,
    input logic ARESET,
    axis_pkt_mux_if.slave bus
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    typedef enum logic {IDLE, LOCK} state_t;
    state_t state, state_nx;
    logic [SEL_W-1:0] grant_q, grant_nx, rr_ptr, rr_nx, rr_ch;
    logic [DATA_W-1:0] g_data;
    logic rr_hit, sel_hit, rdy, acc, g_last;
    assign rdy = (state == LOCK) && (!bus.M_TVALID || bus.M_TREADY);
    assign acc = rdy && bus.S_TVALID[grant_q];
    assign g_last = bus.S_TLAST[grant_q];
    assign bus.S_TREADY = rdy ? NUM_CH'(1) << grant_q : '0;
    assign bus.busy = state == LOCK;
    assign bus.grant = grant_q;
    assign sel_hit = ({1'b0, bus.sel} < (SEL_W + 1)'(NUM_CH)) && bus.S_TVALID[bus.sel];
    always_comb begin
        g_data = '0;
        for (int j = 0; j < NUM_CH; j++)
            if (j == int'(grant_q)) g_data = bus.S_TDATA[j*DATA_W +: DATA_W];
    end
    // Wrapped half first; the half after rr_ptr overrides, so the nearest channel after rr_ptr wins
    always_comb begin
        rr_hit = 1'b0;
        rr_ch = '0;
        for (int j = NUM_CH - 1; j >= 0; j--)
            if (bus.S_TVALID[j] && j <= int'(rr_ptr)) begin
                rr_hit = 1'b1;
                rr_ch = SEL_W'(j);
            end
        for (int j = NUM_CH - 1; j >= 0; j--)
            if (bus.S_TVALID[j] && j > int'(rr_ptr)) begin
                rr_hit = 1'b1;
                rr_ch = SEL_W'(j);
            end
    end
    always_comb begin
        state_nx = state;
        grant_nx = grant_q;
        rr_nx = rr_ptr;
        if (state == IDLE) begin
            if (MODE == 0 && sel_hit) begin
                state_nx = LOCK;
                grant_nx = bus.sel;
            end else if (MODE != 0 && rr_hit) begin
                state_nx = LOCK;
                grant_nx = rr_ch;
                rr_nx = rr_ch;
            end
        end else if (acc && g_last) begin
            state_nx = IDLE;
        end
    end
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
            grant_q <= '0;
            rr_ptr <= SEL_W'(NUM_CH - 1);
            bus.M_TVALID <= 1'b0;
            bus.M_TLAST <= 1'b0;
            bus.M_TDATA <= '0;
        end else begin
            state <= state_nx;
            grant_q <= grant_nx;
            rr_ptr <= rr_nx;
            if (acc) begin
                bus.M_TDATA <= g_data;
                bus.M_TLAST <= g_last;
                bus.M_TVALID <= 1'b1;
            end else if (bus.M_TREADY) begin
                bus.M_TVALID <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_pkt_mux.sv
// tb_axis_pkt_mux: scoreboard bench for axis_pkt_mux, one instance per MODE,
// directed timing checks followed by a randomized long run.
module tb_axis_pkt_mux;
    localparam int N = 4;
    localparam int W = 8;
    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;
    axis_pkt_mux_if #(.NUM_CH(N), .DATA_W(W)) b0 ();
    axis_pkt_mux_if #(.NUM_CH(N), .DATA_W(W)) b1 ();
    axis_pkt_mux #(.NUM_CH(N), .DATA_W(W), .MODE(0)) dut0 (.ACLK(ACLK), .ARESET(ARESET), .bus(b0));
    axis_pkt_mux #(.NUM_CH(N), .DATA_W(W), .MODE(1)) dut1 (.ACLK(ACLK), .ARESET(ARESET), .bus(b1));
    logic [8:0] src [2*N][$];
    logic [8:0] expq [2*N][$];
    int ord [2][$];
    logic [5:0] seq [2*N];
    int n_cmp = 0;
    int n_bad = 0;
    int nbeats [2];
    int last_ch [2];
    int cur [2];
    bit in_pkt [2];
    bit rr_chk = 1'b0;
    bit rnd = 1'b0;
    bit tr_fix = 1'b1;
    logic [7:0] t1d [3] = '{8'h11, 8'h22, 8'h33};
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, want, $time);
        end
    endtask
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask
    task automatic push(input int d, input int c, input logic [7:0] dt, input logic l);
        src[d*N+c].push_back({l, dt});
        expq[d*N+c].push_back({l, dt});
    endtask
    task automatic rpkt(input int d, input int c);
        int len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
            push(d, c, {c[1:0], seq[d*N+c]}, i == len - 1);
            seq[d*N+c] = seq[d*N+c] + 6'd1;
        end
    endtask
    task automatic flush();
        for (int i = 0; i < 2*N; i++) begin
            src[i].delete();
            expq[i].delete();
        end
        ord[0].delete();
        ord[1].delete();
    endtask
    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < 2*N; i++) if (expq[i].size() > 0) p = 1'b1;
        return p;
    endfunction
    // Source side: present queue heads after the falling edge, retire accepted beats just before the rising edge
    initial forever begin
        @(negedge ACLK);
        b0.M_TREADY = rnd ? ($urandom_range(0, 3) != 0) : tr_fix;
        b1.M_TREADY = rnd ? ($urandom_range(0, 3) != 0) : tr_fix;
        for (int c = 0; c < N; c++) begin
            logic [8:0] h0, h1;
            h0 = src[c].size() > 0 ? src[c][0] : 9'h0;
            h1 = src[N+c].size() > 0 ? src[N+c][0] : 9'h0;
            b0.S_TVALID[c] = src[c].size() > 0;
            b0.S_TLAST[c] = h0[8];
            b0.S_TDATA[c*W +: W] = h0[7:0];
            b1.S_TVALID[c] = src[N+c].size() > 0;
            b1.S_TLAST[c] = h1[8];
            b1.S_TDATA[c*W +: W] = h1[7:0];
        end
        #4;
        if (!ARESET)
            for (int c = 0; c < N; c++) begin
                if (b0.S_TVALID[c] && b0.S_TREADY[c]) void'(src[c].pop_front());
                if (b1.S_TVALID[c] && b1.S_TREADY[c]) void'(src[N+c].pop_front());
            end
    end
    // Master-side monitor: each handshaken beat is matched against the packet queue of its channel
    initial forever begin
        @(negedge ACLK);
        #4;
        for (int d = 0; d < 2; d++) begin
            logic v;
            logic [8:0] beat;
            int k;
            v = d == 0 ? (b0.M_TVALID && b0.M_TREADY) : (b1.M_TVALID && b1.M_TREADY);
            beat = d == 0 ? {b0.M_TLAST, b0.M_TDATA} : {b1.M_TLAST, b1.M_TDATA};
            if (ARESET) begin
                in_pkt[d] = 1'b0;
                last_ch[d] = N - 1;
            end else if (v) begin
                if (!in_pkt[d]) begin
                    if (ord[d].size() > 0) cur[d] = ord[d].pop_front();
                    else cur[d] = int'(beat[7:6]);
                    if (rr_chk && d == 1) chk("rr_order", cur[d], (last_ch[d] + 1) % N);
                    last_ch[d] = cur[d];
                end
                k = d*N + cur[d];
                chk("beat_expected", expq[k].size() > 0, 1);
                if (expq[k].size() > 0) chk("beat", beat, expq[k].pop_front());
                in_pkt[d] = !beat[8];
                nbeats[d]++;
            end
        end
    end
    initial begin
        int t;
        for (int i = 0; i < 2*N; i++) seq[i] = '0;
        b0.sel = '0;
        b1.sel = '0;
        cyc(2);
        chk("rst_tvalid0", b0.M_TVALID, 0);
        chk("rst_tlast0", b0.M_TLAST, 0);
        chk("rst_tdata0", b0.M_TDATA, 0);
        chk("rst_busy0", b0.busy, 0);
        chk("rst_grant0", b0.grant, 0);
        chk("rst_sready0", b0.S_TREADY, 0);
        chk("rst_tvalid1", b1.M_TVALID, 0);
        chk("rst_busy1", b1.busy, 0);
        chk("rst_sready1", b1.S_TREADY, 0);
        ARESET = 1'b0;
        b0.sel = 2'd2;
        push(0, 2, 8'h11, 0);
        push(0, 2, 8'h22, 0);
        push(0, 2, 8'h33, 1);
        ord[0].push_back(2);
        cyc();
        chk("t1_busy", b0.busy, 1);
        chk("t1_grant", b0.grant, 2);
        chk("t1_latency", b0.M_TVALID, 0);
        chk("t1_sready", b0.S_TREADY, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t1_tvalid", b0.M_TVALID, 1);
            chk("t1_tdata", b0.M_TDATA, t1d[i]);
            chk("t1_tlast", b0.M_TLAST, i == 2);
            chk("t1_other_sready", b0.S_TREADY & 4'b1011, 0);
        end
        chk("t1_busy_end", b0.busy, 0);
        chk("t1_grant_hold", b0.grant, 2);
        cyc(2);
        push(0, 2, 8'h41, 0);
        push(0, 2, 8'h42, 0);
        push(0, 2, 8'h43, 1);
        push(0, 1, 8'h51, 0);
        push(0, 1, 8'h52, 1);
        ord[0].push_back(2);
        ord[0].push_back(1);
        cyc(2);
        chk("t2_first", b0.M_TDATA, 8'h41);
        b0.sel = 2'd1;
        cyc();
        chk("t2_lock_busy", b0.busy, 1);
        chk("t2_lock_grant", b0.grant, 2);
        cyc();
        chk("t2_idle_busy", b0.busy, 0);
        chk("t2_idle_grant", b0.grant, 2);
        cyc();
        chk("t2_next_busy", b0.busy, 1);
        chk("t2_next_grant", b0.grant, 1);
        cyc(4);
        b0.sel = 2'd0;
        push(0, 0, 8'h61, 0);
        push(0, 0, 8'h62, 0);
        push(0, 0, 8'h63, 0);
        push(0, 0, 8'h64, 1);
        ord[0].push_back(0);
        cyc(2);
        chk("t4_first", b0.M_TDATA, 8'h61);
        tr_fix = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_tvalid", b0.M_TVALID, 1);
            chk("t4_stable", b0.M_TDATA, 8'h61);
            chk("t4_sready", b0.S_TREADY, 0);
        end
        tr_fix = 1'b1;
        cyc(6);
        for (int i = 0; i < 5; i++) begin
            push(1, 3, 8'(8'h70 + i), 1);
            ord[1].push_back(3);
        end
        for (int i = 1; i <= 11; i++) begin
            cyc();
            chk("t5_spacing", b1.M_TVALID, (i % 2 == 0) && (i <= 10));
            if (b1.M_TVALID) chk("t5_tlast", b1.M_TLAST, 1);
        end
        push(1, 2, 8'h81, 0);
        push(1, 2, 8'h82, 0);
        push(1, 2, 8'h83, 0);
        push(1, 2, 8'h84, 1);
        ord[1].push_back(2);
        cyc(2);
        chk("t6_pre_grant", b1.grant, 2);
        chk("t6_pre_busy", b1.busy, 1);
        ARESET = 1'b1;
        #1;
        chk("t6_tvalid", b1.M_TVALID, 0);
        chk("t6_busy", b1.busy, 0);
        chk("t6_grant", b1.grant, 0);
        chk("t6_sready", b1.S_TREADY, 0);
        flush();
        cyc(2);
        ARESET = 1'b0;
        push(1, 2, 8'h91, 1);
        push(1, 0, 8'hA1, 0);
        push(1, 0, 8'hA2, 1);
        ord[1].push_back(0);
        ord[1].push_back(2);
        cyc();
        chk("t6_prio_grant", b1.grant, 0);
        chk("t6_prio_busy", b1.busy, 1);
        cyc(6);
        ARESET = 1'b1;
        flush();
        cyc(2);
        nbeats[0] = 0;
        nbeats[1] = 0;
        rnd = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < N; c++) begin
                rpkt(d, c);
                rpkt(d, c);
            end
        ARESET = 1'b0;
        rr_chk = 1'b1;
        t = 0;
        while ((nbeats[0] < 1000 || nbeats[1] < 1000) && t < 20000) begin
            b0.sel = 2'($urandom_range(0, N - 1));
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < N; c++)
                    if (src[d*N+c].size() < 6) rpkt(d, c);
            cyc();
            t++;
        end
        rr_chk = 1'b0;
        chk("rand_budget", t < 20000, 1);
        t = 0;
        while (pending() && t < 3000) begin
            b0.sel = 2'($urandom_range(0, N - 1));
            cyc();
            t++;
        end
        chk("drain", pending(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
